// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and latency-class encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] R_FORMAT = 6'h00;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2b;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] BNE      = 6'h05;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] ORI      = 6'h0d;

    // R-format function codes (instr[5:0])
    localparam logic [5:0] JR       = 6'h08;
    localparam logic [5:0] SLL      = 6'h00;
    localparam logic [5:0] MFHI     = 6'h10;
    localparam logic [5:0] MFLO     = 6'h12;
    localparam logic [5:0] DIVU     = 6'h1b;

    // All-zero word; decodes as sll $0,$0,0 but is treated as a bubble.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    localparam int CLS_W = 4;

    typedef enum logic [CLS_W-1:0] {
        CLS_NOP,
        CLS_R,
        CLS_LW,
        CLS_I,
        CLS_BR,
        CLS_J,
        CLS_DIV,
        CLS_HILO,
        CLS_DEF
    } cls_t;

endpackage

// File: rtl/instr_classifier.sv
// Decodes a fetched instruction word into its stall latency class.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows i_instr every cycle.
//
// Ports:
//   i_instr  [31:0]       fetched instruction word
//   o_cls    [CLS_W-1:0]  latency class (cls_t encoding)
module instr_classifier
    import mips_pkg::*;
(
    input  logic [31:0]      i_instr,
    output logic [CLS_W-1:0] o_cls
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    cls_t       w_cls;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    // The zero-word test comes first so sll $0,$0,0 is a NOP, not an R op.
    always_comb begin
        w_cls = CLS_DEF;
        if (i_instr == NOP_WORD) begin
            w_cls = CLS_NOP;
        end else if (w_opcode == R_FORMAT) begin
            case (w_funct)
                DIVU:       w_cls = CLS_DIV;
                MFHI, MFLO: w_cls = CLS_HILO;
                default:    w_cls = CLS_R;    // includes JR and SLL
            endcase
        end else begin
            case (w_opcode)
                LW:       w_cls = CLS_LW;
                SW, ORI:  w_cls = CLS_I;
                BEQ, BNE: w_cls = CLS_BR;
                J:        w_cls = CLS_J;
                default:  w_cls = CLS_DEF;
            endcase
        end
    end

    assign o_cls = w_cls;

endmodule

// File: rtl/stall_sequencer.sv
// PC-stall controller: holds the PC for a per-class number of cycles, divu runs in background.
// Latency: pc_en is combinational on current state/inputs; counters update on the next clk edge.
// Backpressure: o_pc_en low while stalling or while mfhi/mflo/divu wait on a busy divider.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_instr_valid      i_instr holds a fetched instruction
//   i_instr [31:0]     fetched instruction word
//   i_flush            redirect from branch resolution; aborts a stall, blocks acceptance
//   o_pc_en            PC may advance; accept = i_instr_valid & o_pc_en & ~i_flush
//   o_stall            ~o_pc_en
//   o_stall_cnt        remaining front-end stall cycles
//   o_div_busy         divider occupied
//   o_div_cnt          remaining divider cycles
module stall_sequencer
    import mips_pkg::*;
#(
    parameter int CNT_W         = 6,
    parameter int LAT_R         = 3,
    parameter int LAT_LW        = 3,
    parameter int LAT_I         = 3,
    parameter int LAT_BR        = 2,
    parameter int LAT_J         = 1,
    parameter int LAT_NOP       = 1,
    parameter int LAT_DIV       = 31,
    parameter int LAT_DIV_ISSUE = 1,
    parameter int LAT_HILO      = 0,
    parameter int LAT_DEFAULT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_instr_valid,
    input  logic [31:0]      i_instr,
    input  logic             i_flush,
    output logic             o_pc_en,
    output logic             o_stall,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic             o_div_busy,
    output logic [CNT_W-1:0] o_div_cnt
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Every latency must fit the counters; a counter that cannot hold its
    // load value would silently shorten the stall.
    generate
        if (LAT_R < 0 || LAT_R > CNT_MAX) begin : g_bad_lat_r
            $error("LAT_R out of range for CNT_W");
        end
        if (LAT_LW < 0 || LAT_LW > CNT_MAX) begin : g_bad_lat_lw
            $error("LAT_LW out of range for CNT_W");
        end
        if (LAT_I < 0 || LAT_I > CNT_MAX) begin : g_bad_lat_i
            $error("LAT_I out of range for CNT_W");
        end
        if (LAT_BR < 0 || LAT_BR > CNT_MAX) begin : g_bad_lat_br
            $error("LAT_BR out of range for CNT_W");
        end
        if (LAT_J < 0 || LAT_J > CNT_MAX) begin : g_bad_lat_j
            $error("LAT_J out of range for CNT_W");
        end
        if (LAT_NOP < 0 || LAT_NOP > CNT_MAX) begin : g_bad_lat_nop
            $error("LAT_NOP out of range for CNT_W");
        end
        if (LAT_DIV < 0 || LAT_DIV > CNT_MAX) begin : g_bad_lat_div
            $error("LAT_DIV out of range for CNT_W");
        end
        if (LAT_DIV_ISSUE < 0 || LAT_DIV_ISSUE > CNT_MAX) begin : g_bad_lat_div_issue
            $error("LAT_DIV_ISSUE out of range for CNT_W");
        end
        if (LAT_HILO < 0 || LAT_HILO > CNT_MAX) begin : g_bad_lat_hilo
            $error("LAT_HILO out of range for CNT_W");
        end
        if (LAT_DEFAULT < 0 || LAT_DEFAULT > CNT_MAX) begin : g_bad_lat_default
            $error("LAT_DEFAULT out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] L_R         = CNT_W'(LAT_R);
    localparam logic [CNT_W-1:0] L_LW        = CNT_W'(LAT_LW);
    localparam logic [CNT_W-1:0] L_I         = CNT_W'(LAT_I);
    localparam logic [CNT_W-1:0] L_BR        = CNT_W'(LAT_BR);
    localparam logic [CNT_W-1:0] L_J         = CNT_W'(LAT_J);
    localparam logic [CNT_W-1:0] L_NOP       = CNT_W'(LAT_NOP);
    localparam logic [CNT_W-1:0] L_DIV       = CNT_W'(LAT_DIV);
    localparam logic [CNT_W-1:0] L_DIV_ISSUE = CNT_W'(LAT_DIV_ISSUE);
    localparam logic [CNT_W-1:0] L_HILO      = CNT_W'(LAT_HILO);
    localparam logic [CNT_W-1:0] L_DEFAULT   = CNT_W'(LAT_DEFAULT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_STALL
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] w_stall_cnt_nxt;
    logic [CNT_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] w_div_cnt_nxt;

    logic [CLS_W-1:0] w_cls_raw;
    cls_t             w_cls;
    logic [CNT_W-1:0] w_lat;
    logic             w_div_busy;
    logic             w_needs_div;
    logic             w_block;
    logic             w_idle;
    logic             w_pc_en;
    logic             w_accept;

    instr_classifier u_classifier (
        .i_instr (i_instr),
        .o_cls   (w_cls_raw)
    );

    assign w_cls = cls_t'(w_cls_raw);

    // Class -> front-end stall length. A divu only costs the issue slot up
    // front; its full occupancy is tracked by the divider counter.
    always_comb begin
        w_lat = L_DEFAULT;
        case (w_cls)
            CLS_NOP:  w_lat = L_NOP;
            CLS_R:    w_lat = L_R;
            CLS_LW:   w_lat = L_LW;
            CLS_I:    w_lat = L_I;
            CLS_BR:   w_lat = L_BR;
            CLS_J:    w_lat = L_J;
            CLS_DIV:  w_lat = L_DIV_ISSUE;
            CLS_HILO: w_lat = L_HILO;
            default:  w_lat = L_DEFAULT;
        endcase
    end

    // Busy is taken from the registered count, so a mfhi presented in the
    // cycle the divider counts 1->0 still waits one cycle.
    assign w_div_busy  = (r_div_cnt != '0);
    assign w_needs_div = (w_cls == CLS_HILO) || (w_cls == CLS_DIV);
    assign w_block     = i_instr_valid & w_div_busy & w_needs_div;
    assign w_idle      = (r_state == ST_IDLE);

    // A flush in IDLE must let the redirect target load even if the
    // instruction on the fetch bus would otherwise be blocked.
    assign w_pc_en  = ~rst & w_idle & (i_flush | ~w_block);
    assign w_accept = i_instr_valid & w_pc_en & ~i_flush;

    // Stall FSM: next state and stall counter.
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        case (r_state)
            ST_IDLE: begin
                // L cycles of stall: the STALL state lasts cnt+1 cycles.
                if (w_accept && (w_lat != '0)) begin
                    w_state_nxt     = ST_STALL;
                    w_stall_cnt_nxt = w_lat - CNT_ONE;
                end
            end
            ST_STALL: begin
                if (i_flush) begin
                    w_state_nxt     = ST_IDLE;
                    w_stall_cnt_nxt = '0;
                end else if (r_stall_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall_cnt_nxt = r_stall_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_stall_cnt_nxt = '0;
            end
        endcase
    end

    // Divider occupancy: free-running down-counter, ignores FSM state and
    // flush. A new divu can only be accepted once it has reached zero.
    always_comb begin
        w_div_cnt_nxt = r_div_cnt;
        if (w_accept && (w_cls == CLS_DIV)) begin
            w_div_cnt_nxt = L_DIV;
        end else if (w_div_busy) begin
            w_div_cnt_nxt = r_div_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_stall_cnt <= '0;
            r_div_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_div_cnt   <= w_div_cnt_nxt;
        end
    end

    assign o_pc_en     = w_pc_en;
    assign o_stall     = ~w_pc_en;
    assign o_stall_cnt = r_stall_cnt;
    assign o_div_busy  = w_div_busy;
    assign o_div_cnt   = r_div_cnt;

endmodule

// File: tb/tb_stall_sequencer.sv
// Directed bench for stall_sequencer: default build plus a reparameterised copy.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_stall_sequencer;

    localparam logic [31:0] I_LW   = 32'h8C08_0000;
    localparam logic [31:0] I_BEQ  = 32'h1109_0003;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_DIVU = 32'h0109_001B;
    localparam logic [31:0] I_ADD  = 32'h0109_5020;
    localparam logic [31:0] I_MFHI = 32'h0000_5010;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        flush;

    logic        pc_en;
    logic        stall;
    logic [5:0]  stall_cnt;
    logic        div_busy;
    logic [5:0]  div_cnt;

    logic        pc_en2;
    logic        stall2;
    logic [3:0]  stall_cnt2;
    logic        div_busy2;
    logic [3:0]  div_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stall_sequencer u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_instr_valid (instr_valid),
        .i_instr       (instr),
        .i_flush       (flush),
        .o_pc_en       (pc_en),
        .o_stall       (stall),
        .o_stall_cnt   (stall_cnt),
        .o_div_busy    (div_busy),
        .o_div_cnt     (div_cnt)
    );

    stall_sequencer #(
        .CNT_W   (4),
        .LAT_R   (0),
        .LAT_DIV (15)
    ) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .i_instr_valid (instr_valid),
        .i_instr       (instr),
        .i_flush       (flush),
        .o_pc_en       (pc_en2),
        .o_stall       (stall2),
        .o_stall_cnt   (stall_cnt2),
        .o_div_busy    (div_busy2),
        .o_div_cnt     (div_cnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_valid = 1'b0; flush = 1'b0; instr = 32'h0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (pc_en !== 1'b0) begin n_errors++; $display("FAIL rst_pc_en got=%b exp=0", pc_en); end
        n_checks++;
        if (stall_cnt !== 6'd0 || div_cnt !== 6'd0) begin
            n_errors++; $display("FAIL rst_counters stall_cnt=%0d div_cnt=%0d exp=0,0", stall_cnt, div_cnt);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || stall !== 1'b0) begin
            n_errors++; $display("FAIL post_rst_pc_en pc_en=%b stall=%b exp=1,0", pc_en, stall);
        end
        n_checks++;
        if (div_busy !== 1'b0 || stall_cnt !== 6'd0 || div_cnt !== 6'd0) begin
            n_errors++; $display("FAIL post_rst_state div_busy=%b stall_cnt=%0d div_cnt=%0d exp=0,0,0",
                                 div_busy, stall_cnt, div_cnt);
        end
        step();
    endtask

    task automatic test_lw();
        logic [5:0] exp_cnt;
        do_reset();
        instr = I_LW; instr_valid = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b1) begin n_errors++; $display("FAIL lw_accept pc_en=%b exp=1", pc_en); end
        step();
        instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_cnt = 6'(2 - k);
            #1;
            n_checks++;
            if (pc_en !== 1'b0 || stall !== 1'b1 || stall_cnt !== exp_cnt) begin
                n_errors++; $display("FAIL lw_stall%0d pc_en=%b stall=%b stall_cnt=%0d exp=0,1,%0d",
                                     k, pc_en, stall, stall_cnt, exp_cnt);
            end
            step();
        end
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || stall_cnt !== 6'd0) begin
            n_errors++; $display("FAIL lw_release pc_en=%b stall_cnt=%0d exp=1,0", pc_en, stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_pc;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            instr       = (c == 0) ? I_BEQ : I_J;
            instr_valid = (c < 5);
            exp_pc      = (c == 0) || (c == 3) || (c == 5);
            #1;
            n_checks++;
            if (pc_en !== exp_pc) begin
                n_errors++; $display("FAIL b2b_cycle%0d pc_en=%b exp=%b", c, pc_en, exp_pc);
            end
            step();
        end
    endtask

    task automatic test_divu();
        int   busy_cycles;
        logic exp_pc;
        do_reset();
        busy_cycles = 0;
        instr = I_DIVU; instr_valid = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b1) begin n_errors++; $display("FAIL divu_accept pc_en=%b exp=1", pc_en); end
        step();
        // c1..c31: add waits out the issue slot, is accepted at c2, then mfhi waits on the divider.
        for (int c = 1; c < 32; c++) begin
            instr  = (c < 3) ? I_ADD : I_MFHI;
            exp_pc = (c == 2);
            #1;
            if (c == 1) begin
                n_checks++;
                if (div_cnt !== 6'd31) begin
                    n_errors++; $display("FAIL divu_load div_cnt=%0d exp=31", div_cnt);
                end
            end
            if (div_busy === 1'b1) busy_cycles++;
            n_checks++;
            if (pc_en !== exp_pc) begin
                n_errors++; $display("FAIL divu_cycle%0d pc_en=%b exp=%b", c, pc_en, exp_pc);
            end
            step();
        end
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || div_busy !== 1'b0 || div_cnt !== 6'd0) begin
            n_errors++; $display("FAIL mfhi_accept pc_en=%b div_busy=%b div_cnt=%0d exp=1,0,0",
                                 pc_en, div_busy, div_cnt);
        end
        n_checks++;
        if (busy_cycles != 31) begin
            n_errors++; $display("FAIL divu_busy_len got=%0d exp=31", busy_cycles);
        end
        step();
        instr_valid = 1'b0; #1;
        n_checks++;
        if (pc_en !== 1'b1 || stall !== 1'b0) begin
            n_errors++; $display("FAIL mfhi_no_penalty pc_en=%b stall=%b exp=1,0", pc_en, stall);
        end
        step();
    endtask

    task automatic test_flush();
        do_reset();
        instr = I_DIVU; instr_valid = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b1) begin n_errors++; $display("FAIL fl_divu_accept pc_en=%b exp=1", pc_en); end
        step();
        instr_valid = 1'b0; step();
        instr = I_LW; instr_valid = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b1) begin n_errors++; $display("FAIL fl_lw_accept pc_en=%b exp=1", pc_en); end
        step();
        instr_valid = 1'b0; step();
        flush = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b0 || stall_cnt !== 6'd1) begin
            n_errors++; $display("FAIL fl_in_stall pc_en=%b stall_cnt=%0d exp=0,1", pc_en, stall_cnt);
        end
        step();
        // Flush again in IDLE with a valid lw: PC loads, lw is not accepted.
        flush = 1'b1; instr = I_LW; instr_valid = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b1 || stall_cnt !== 6'd0 || div_cnt !== 6'd27) begin
            n_errors++; $display("FAIL fl_abort pc_en=%b stall_cnt=%0d div_cnt=%0d exp=1,0,27",
                                 pc_en, stall_cnt, div_cnt);
        end
        step();
        flush = 1'b0; instr_valid = 1'b0; #1;
        n_checks++;
        if (pc_en !== 1'b1 || stall_cnt !== 6'd0 || div_busy !== 1'b1 || div_cnt !== 6'd26) begin
            n_errors++; $display("FAIL fl_idle_suppress pc_en=%b stall_cnt=%0d div_busy=%b div_cnt=%0d exp=1,0,1,26",
                                 pc_en, stall_cnt, div_busy, div_cnt);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        instr = I_DIVU; instr_valid = 1'b1; step();
        instr_valid = 1'b0; step();
        instr = I_LW; instr_valid = 1'b1; step();
        instr_valid = 1'b0; rst = 1'b1; #1;
        n_checks++;
        if (pc_en !== 1'b0 || stall_cnt !== 6'd2 || div_cnt !== 6'd29) begin
            n_errors++; $display("FAIL rm_before pc_en=%b stall_cnt=%0d div_cnt=%0d exp=0,2,29",
                                 pc_en, stall_cnt, div_cnt);
        end
        step();
        rst = 1'b0; #1;
        n_checks++;
        if (stall_cnt !== 6'd0 || div_cnt !== 6'd0 || div_busy !== 1'b0) begin
            n_errors++; $display("FAIL rm_cleared stall_cnt=%0d div_cnt=%0d div_busy=%b exp=0,0,0",
                                 stall_cnt, div_cnt, div_busy);
        end
        n_checks++;
        if (pc_en !== 1'b1) begin n_errors++; $display("FAIL rm_pc_en pc_en=%b exp=1", pc_en); end
        step();
    endtask

    task automatic test_reparam();
        int busy_cycles;
        do_reset();
        busy_cycles = 0;
        instr = I_ADD; instr_valid = 1'b1; #1;
        n_checks++;
        if (pc_en2 !== 1'b1) begin n_errors++; $display("FAIL rp_add0 pc_en=%b exp=1", pc_en2); end
        step();
        #1;
        n_checks++;
        if (pc_en2 !== 1'b1 || stall2 !== 1'b0 || stall_cnt2 !== 4'd0) begin
            n_errors++; $display("FAIL rp_add1 pc_en=%b stall=%b stall_cnt=%0d exp=1,0,0",
                                 pc_en2, stall2, stall_cnt2);
        end
        step();
        instr = I_DIVU; #1;
        n_checks++;
        if (pc_en2 !== 1'b1) begin n_errors++; $display("FAIL rp_divu_accept pc_en=%b exp=1", pc_en2); end
        step();
        instr_valid = 1'b0; #1;
        n_checks++;
        if (pc_en2 !== 1'b0 || div_cnt2 !== 4'd15) begin
            n_errors++; $display("FAIL rp_divu_issue pc_en=%b div_cnt=%0d exp=0,15", pc_en2, div_cnt2);
        end
        for (int c = 0; c < 20; c++) begin
            if (div_busy2 === 1'b1) busy_cycles++;
            step();
        end
        n_checks++;
        if (busy_cycles != 15 || div_cnt2 !== 4'd0) begin
            n_errors++; $display("FAIL rp_div_len busy=%0d div_cnt=%0d exp=15,0", busy_cycles, div_cnt2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr = 32'h0; flush = 1'b0;
        step();
        step();
        test_reset();
        test_lw();
        test_back_to_back();
        test_divu();
        test_flush();
        test_reset_mid();
        test_reparam();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stall_sequencer.md
Name: stall_sequencer

Overview:
- Parametrised PC-stall controller for the 5-stage MIPS pipeline; successor to the fixed-count hazard stall counter.
- Decodes each fetched instruction into a latency class and holds the PC for a per-class, parameter-set number of cycles.
- Runs divu in the background: only mfhi/mflo and a second divu interlock on the divider.
- Supports a redirect flush that aborts an in-progress stall.

Parameters:
- CNT_W, 6: width of stall and divider counters; every LAT_* must be <= 2**CNT_W-1.
- LAT_R, 3: stall cycles for R-format ALU ops, including jr and sll.
- LAT_LW, 3: stall cycles for lw.
- LAT_I, 3: stall cycles for sw and ori.
- LAT_BR, 2: stall cycles for beq and bne.
- LAT_J, 1: stall cycles for j.
- LAT_NOP, 1: stall cycles for the all-zero word.
- LAT_DIV, 31: background divider occupancy, in cycles.
- LAT_DIV_ISSUE, 1: front-end stall cycles when divu issues.
- LAT_HILO, 0: stall cycles for mfhi/mflo once the divider is free.
- LAT_DEFAULT, 0: stall cycles for any other opcode.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- instr_valid, input, 1: instr holds a fetched instruction.
- instr, input, 32: fetched instruction word.
- flush, input, 1: redirect/flush request from branch resolution.
- pc_en, output, 1: PC may advance; instruction accepted when instr_valid & pc_en & ~flush.
- stall, output, 1: equals ~pc_en.
- stall_cnt, output, CNT_W: remaining front-end stall cycles.
- div_busy, output, 1: divider occupied.
- div_cnt, output, CNT_W: remaining divider cycles.

Behaviour:
- Classification is combinational, in this priority order:
  - instr==0 -> NOP.
  - opcode 0 with funct 0x1b -> DIV.
  - opcode 0 with funct 0x10 or 0x12 -> HILO.
  - any other opcode 0 -> R.
  - opcode 35 -> LW.
  - opcode 43 or 0x0d -> I.
  - opcode 4 or 5 -> BR.
  - opcode 2 -> J.
  - else DEFAULT.
- The NOP check precedes the R check, so sll $0,$0,0 is NOP.
- FSM states: IDLE, STALL.
- pc_en = ~rst & (state==IDLE) & ~block, where block = instr_valid & div_busy & (class==HILO or class==DIV).
- When flush=1 and state==IDLE, pc_en=1 (redirect load) and no instruction is accepted.
- IDLE, on acceptance with class latency L:
  - L==0: remain in IDLE.
  - L>0: stall_cnt <= L-1, go to STALL.
  - pc_en is therefore high in the acceptance cycle and low for exactly L following cycles.
- STALL: pc_en=0.
  - stall_cnt==0 -> IDLE.
  - otherwise stall_cnt decrements.
- DIV acceptance:
  - additionally loads div_cnt <= LAT_DIV.
  - issue stall is LAT_DIV_ISSUE.
- Divider counter:
  - div_cnt decrements every cycle while nonzero, independent of FSM state and of flush.
  - div_busy = (div_cnt != 0).
- Blocked HILO/DIV:
  - held in IDLE, pc_en=0, not accepted.
  - accepted in the first cycle div_cnt==0, with no extra penalty.
- flush in STALL: next state IDLE, stall_cnt <= 0. flush never clears div_cnt.
- flush in IDLE: acceptance suppressed; state and counters unchanged.
- rst (synchronous) takes priority over everything:
  - state IDLE, stall_cnt 0, div_cnt 0.
  - pc_en=0 while rst high.
  - Values after the rst-low edge: pc_en=1 (absent block), stall=0, stall_cnt=0, div_busy=0, div_cnt=0.
  - Reset mid-stall or mid-divide aborts both immediately.
- instr_valid=0 in IDLE: no acceptance, pc_en stays 1.
- Simultaneous events:
  - div_cnt reaching 0 in the same cycle a HILO is presented: block is evaluated on the registered div_cnt, so the HILO is blocked this cycle and accepted next.
  - flush and valid together in IDLE: flush wins.
- No wrap-around: counters never decrement below 0, and LAT_* are bounded by CNT_W (out-of-range values are an elaboration error).

Decomposition:
- Shared package mips_pkg:
  - opcode constants R_FORMAT, LW, SW, BEQ, BNE, J, ORI.
  - funct constants JR, SLL, MFHI, MFLO, DIVU.
  - NOP word.
  - latency-class enum {CLS_NOP, CLS_R, CLS_LW, CLS_I, CLS_BR, CLS_J, CLS_DIV, CLS_HILO, CLS_DEF}.
- One combinational sub-module, instr_classifier: instr -> class. stall_sequencer maps class -> LAT_* and holds the FSM and both counters.

Test Plan:
- Reset, then lw (0x8C080000) valid one cycle -> pc_en 1 at accept, 0 for 3 cycles, 1 after; stall_cnt 2,1,0.
- beq (0x11090003) then j (0x08000010) back-to-back with valid held -> pc_en pattern 1,0,0,1,0,1.
- divu (0x0109001B), then add, then mfhi (0x00005010) -> div_busy high 31 cycles; add accepted after the 1-cycle issue stall; mfhi blocked until the cycle after div_cnt reaches 0; pc_en 0 throughout.
- lw accepted, flush asserted on second stall cycle -> IDLE next cycle, pc_en=1, stall_cnt=0; a divu in flight keeps counting.
- rst asserted mid-divide and mid-stall -> next cycle stall_cnt=0, div_cnt=0, div_busy=0; pc_en=1 after rst drops.
- Reparameterise LAT_R=0, CNT_W=4, LAT_DIV=15 -> R ops never stall; divu occupancy exactly 15 cycles.
